// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Word-addressed instruction fetch stage. The PC drives program memory
//   directly; the returned word is latched into IR on each fetch edge. A stall
//   freezes fetch, an external redirect (Branch_Taken) overrides the next PC,
//   and fetching the all-zero word halts the unit until reset.
//
// Optional feature (macro IFETCH_LOCAL_BRANCH_EN):
//   When defined, a fetched nonzero word with bits[31:30] == 2'b00 is a local
//   branch: next PC = PC + sign-extended bits[21:0]. An external redirect
//   still has priority. When undefined, such words advance the PC by one.
//
// Parameters:
//   DATAWIDTH_BUS  width of address, instruction and target buses (>= 32)
//   RESET_VECTOR   first fetch address after reset
//
// Ports:
//   CLOCK_50        in   clock, all state changes on rising edge
//   RESET_InHigh    in   asynchronous active-high reset
//   BusDirecciones  out  word address to program memory (registered PC)
//   BusDatos        in   instruction word from program memory (combinational)
//   Fetch_Stall     in   freezes fetch while high
//   Branch_Taken    in   external redirect request
//   Branch_Target   in   redirect address, used when Branch_Taken is high
//   IR              out  latched instruction
//   IR_Valid        out  IR holds a newly fetched, non-halt instruction
//   Halt            out  the halt word was fetched
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned                DATAWIDTH_BUS = 32,
  parameter logic [DATAWIDTH_BUS-1:0]   RESET_VECTOR  = 32'h0000_0800
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_InHigh,
  output logic [DATAWIDTH_BUS-1:0] BusDirecciones,
  input  logic [DATAWIDTH_BUS-1:0] BusDatos,
  input  logic                     Fetch_Stall,
  input  logic                     Branch_Taken,
  input  logic [DATAWIDTH_BUS-1:0] Branch_Target,
  output logic [DATAWIDTH_BUS-1:0] IR,
  output logic                     IR_Valid,
  output logic                     Halt
);

  localparam logic [DATAWIDTH_BUS-1:0] PC_ONE = {{(DATAWIDTH_BUS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e                   state_q;
  logic [DATAWIDTH_BUS-1:0] pc_q;
  logic [DATAWIDTH_BUS-1:0] ir_q;
  logic                     ir_valid_q;
  logic                     halt_q;
  logic [DATAWIDTH_BUS-1:0] next_pc_d;
  logic                     is_halt_word;

  assign is_halt_word = (BusDatos == '0);

`ifdef IFETCH_LOCAL_BRANCH_EN
  logic                     is_local_branch;
  logic [DATAWIDTH_BUS-1:0] local_offset;

  // The halt word also has bits[31:30] == 0, so it is excluded explicitly.
  assign is_local_branch = (BusDatos[31:30] == 2'b00) && !is_halt_word;
  assign local_offset    = {{(DATAWIDTH_BUS-22){BusDatos[21]}}, BusDatos[21:0]};
`endif

  // Next-PC selection. Addition wraps naturally modulo 2^DATAWIDTH_BUS.
  always_comb begin
    // NOTE: assign a default first so every path drives next_pc_d; a missing
    // branch in combinational logic would otherwise infer a latch.
    next_pc_d = pc_q + PC_ONE;
`ifdef IFETCH_LOCAL_BRANCH_EN
    if (is_local_branch) begin
      next_pc_d = pc_q + local_offset;
    end
`endif
    if (Branch_Taken) begin
      next_pc_d = Branch_Target;
    end
  end

  // Fetch FSM with registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
    if (RESET_InHigh) begin
      state_q    <= FETCH;
      pc_q       <= RESET_VECTOR;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (Fetch_Stall) begin
            // PC and IR hold; a redirect must be re-presented after release.
            state_q    <= STALL;
            ir_valid_q <= 1'b0;
          end else begin
            // The PC advances even on the halt word, including a redirect.
            pc_q <= next_pc_d;
            if (is_halt_word) begin
              state_q    <= HALTED;
              ir_q       <= '0;
              ir_valid_q <= 1'b0;
              halt_q     <= 1'b1;
            end else begin
              ir_q       <= BusDatos;
              ir_valid_q <= 1'b1;
            end
          end
        end

        STALL: begin
          // Release edge only returns to FETCH; the fetch happens one edge later.
          if (!Fetch_Stall) begin
            state_q <= FETCH;
          end
        end

        HALTED: begin
          // Frozen until reset.
        end

        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  assign BusDirecciones = pc_q;
  assign IR             = ir_q;
  assign IR_Valid       = ir_valid_q;
  assign Halt           = halt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. The bench owns a program memory
// (hashed default words plus a few override slots) and a behavioural model of
// the fetch rules; after every clock edge all DUT outputs are compared with
// the model. Directed scenarios cover reset, stall, redirect, local branch
// (result depends on IFETCH_LOCAL_BRANCH_EN), halt, async reset and PC wrap,
// followed by a randomized stretch.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0800;

  logic        clk;
  logic        rst;
  logic [31:0] bus_dir;
  logic [31:0] bus_datos;
  logic        fetch_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] ir;
  logic        ir_valid;
  logic        halt;

  int total;
  int bad;

  instr_fetch_unit #(
    .DATAWIDTH_BUS (32),
    .RESET_VECTOR  (RV)
  ) dut (
    .CLOCK_50       (clk),
    .RESET_InHigh   (rst),
    .BusDirecciones (bus_dir),
    .BusDatos       (bus_datos),
    .Fetch_Stall    (fetch_stall),
    .Branch_Taken   (branch_taken),
    .Branch_Target  (branch_target),
    .IR             (ir),
    .IR_Valid       (ir_valid),
    .Halt           (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- program memory ----------------
  logic [29:0] seed;
  logic        ov_en   [2];
  logic [31:0] ov_addr [2];
  logic [31:0] ov_data [2];

  // Default words have bits[31:30] = 2'b10: never zero, never a local branch.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    logic [29:0] h;
    h = a[29:0] * 30'h2545_F491;
    w = {2'b10, h ^ seed};
    for (int k = 0; k < 2; k++) begin
      if (ov_en[k] && ov_addr[k] == a) w = ov_data[k];
    end
    return w;
  endfunction

  always_comb begin
    bus_datos = mem_word(bus_dir);
  end

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic        m_valid;
  logic        m_halt;
  logic        m_stalled;

  task automatic model_reset();
    m_pc = RV; m_ir = '0; m_valid = 1'b0; m_halt = 1'b0; m_stalled = 1'b0;
  endtask

  task automatic model_step(input logic stall, input logic bt, input logic [31:0] tgt);
    logic [31:0] w;
    logic [31:0] np;
    if (m_halt) begin
      // frozen
    end else if (m_stalled) begin
      m_valid = 1'b0;
      if (!stall) m_stalled = 1'b0;
    end else if (stall) begin
      m_stalled = 1'b1;
      m_valid   = 1'b0;
    end else begin
      w  = mem_word(m_pc);
      np = m_pc + 32'd1;
`ifdef IFETCH_LOCAL_BRANCH_EN
      if (w[31:30] == 2'b00 && w != 32'd0) np = m_pc + 32'($signed(w[21:0]));
`endif
      if (bt) np = tgt;
      if (w == 32'd0) begin
        m_halt = 1'b1; m_ir = '0; m_valid = 1'b0;
      end else begin
        m_ir = w; m_valid = 1'b1;
      end
      m_pc = np;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    bus_dir,         m_pc);
    check({tag, ".ir"},    ir,              m_ir);
    check({tag, ".valid"}, 32'(ir_valid),   32'(m_valid));
    check({tag, ".halt"},  32'(halt),       32'(m_halt));
  endtask

  // Drive inputs, clock one edge, compare #1 after it.
  task automatic cycle(input string tag, input logic stall, input logic bt, input logic [31:0] tgt);
    fetch_stall = stall; branch_taken = bt; branch_target = tgt;
    model_step(stall, bt, tgt);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // Async reset pulse placed between edges; outputs checked while asserted.
  task automatic do_reset(input string tag);
    fetch_stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_model({tag, ".in_reset"});
    rst = 1'b0;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0; bad = 0;
    seed = 30'($urandom);
    ov_en[0] = 1'b0; ov_addr[0] = 32'h807; ov_data[0] = 32'h0CBF_FFFC;
    ov_en[1] = 1'b1; ov_addr[1] = 32'h80E; ov_data[1] = 32'h0000_0000;
    rst = 1'b1; fetch_stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    model_reset();
    @(posedge clk); #1;
    check_model("power_on_reset");
    rst = 1'b0;

    // Reset test: three fetches from the reset vector.
    do_reset("rst");
    for (int i = 0; i < 3; i++) begin
      cycle("rst_run", 1'b0, 1'b0, '0);
      check("rst_pc_const", bus_dir, RV + 32'(i + 1));
      check("rst_ir_const", ir, mem_word(RV + 32'(i)));
    end

    // Stall test at PC = 0x804 (branch requested mid-stall is ignored).
    cycle("pre_stall", 1'b0, 1'b0, '0);
    check("stall_pc_start", bus_dir, 32'h804);
    cycle("stall1", 1'b1, 1'b0, '0);
    cycle("stall2", 1'b1, 1'b1, 32'h123);
    check("stall_pc_hold", bus_dir, 32'h804);
    cycle("stall_release", 1'b0, 1'b0, '0);
    check("release_valid", 32'(ir_valid), 32'd0);
    cycle("stall_refetch", 1'b0, 1'b0, '0);
    check("refetch_ir", ir, mem_word(32'h804));

    // Redirect test at PC = 0x802.
    do_reset("redir");
    cycle("redir_run", 1'b0, 1'b0, '0);
    cycle("redir_run", 1'b0, 1'b0, '0);
    cycle("redir", 1'b0, 1'b1, 32'h900);
    check("redir_pc_const", bus_dir, 32'h900);
    check("redir_ir_const", ir, mem_word(32'h802));

    // Local-branch word at 0x807.
    ov_en[0] = 1'b1;
    do_reset("lbr");
    for (int i = 0; i < 7; i++) cycle("lbr_run", 1'b0, 1'b0, '0);
    cycle("lbr", 1'b0, 1'b0, '0);
`ifdef IFETCH_LOCAL_BRANCH_EN
    check("lbr_pc_const", bus_dir, 32'h803);
`else
    check("lbr_pc_const", bus_dir, 32'h808);
`endif
    check("lbr_ir_const", ir, 32'h0CBF_FFFC);
    check("lbr_valid_const", 32'(ir_valid), 32'd1);
    ov_en[0] = 1'b0;

    // Halt test: zero word at 0x80E, then 10 frozen cycles under random inputs.
    do_reset("halt");
    begin
      int budget;
      budget = 0;
      while (!halt && budget < 20) begin
        cycle("halt_run", 1'b0, 1'b0, '0);
        budget++;
      end
    end
    check("halt_reached", 32'(halt), 32'd1);
    check("halt_valid", 32'(ir_valid), 32'd0);
    check("halt_pc", bus_dir, 32'h80F);
    for (int i = 0; i < 10; i++) begin
      cycle("halted", 1'($urandom), 1'($urandom), $urandom);
      check("halted_pc_const", bus_dir, 32'h80F);
    end

    // Async reset while halted, between edges.
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("areset_halt", 32'(halt), 32'd0);
    check("areset_pc", bus_dir, RV);
    rst = 1'b0;
    #1;
    check_model("areset_released");

    // Halt word and redirect on the same edge.
    do_reset("halt_br");
    for (int i = 0; i < 14; i++) cycle("halt_br_run", 1'b0, 1'b0, '0);
    check("halt_br_pc_start", bus_dir, 32'h80E);
    cycle("halt_br", 1'b0, 1'b1, 32'hA00);
    check("halt_br_pc_const", bus_dir, 32'hA00);
    check("halt_br_halt_const", 32'(halt), 32'd1);

    // PC wrap at the top of the address space.
    do_reset("wrap");
    cycle("wrap_jump", 1'b0, 1'b1, 32'hFFFF_FFFF);
    cycle("wrap", 1'b0, 1'b0, '0);
    check("wrap_pc_const", bus_dir, 32'h0);

    // Randomized stretch with occasional mid-run resets.
    ov_en[0] = 1'b1;
    do_reset("rand");
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      if ($urandom_range(0, 99) < 3) begin
        do_reset("rand_rst");
      end
      tgt = ($urandom_range(0, 1) == 0) ? (32'h800 + 32'($urandom_range(0, 15))) : $urandom;
      cycle("rand", ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 15), tgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter DATAWIDTH_BUS, default 32, setting the width of the address, instruction and target buses.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0800, setting the first fetch address.
REQ-003 The block SHALL have port CLOCK_50, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET_InHigh, input, 1 bit, reset, asynchronous and active-high.
REQ-005 The block SHALL have port BusDirecciones, output, DATAWIDTH_BUS bits, the word address driven to program memory.
REQ-006 The block SHALL have port BusDatos, input, DATAWIDTH_BUS bits, the instruction word returned combinationally by program memory.
REQ-007 The block SHALL have port Fetch_Stall, input, 1 bit, which freezes fetch while high.
REQ-008 The block SHALL have port Branch_Taken, input, 1 bit, an external redirect request.
REQ-009 The block SHALL have port Branch_Target, input, DATAWIDTH_BUS bits, the redirect address sampled when Branch_Taken=1.
REQ-010 The block SHALL have port IR, output, DATAWIDTH_BUS bits, the latched instruction.
REQ-011 The block SHALL have port IR_Valid, output, 1 bit, which marks IR as holding a newly fetched, non-halt instruction.
REQ-012 The block SHALL have port Halt, output, 1 bit, indicating that the halt word was fetched.

Function
REQ-013 BusDirecciones SHALL equal the PC register directly (registered, no combinational path from inputs).
REQ-014 The FSM SHALL have states FETCH, STALL and HALTED.
REQ-015 In FETCH with Fetch_Stall=0, each edge SHALL do three things: IR<=BusDatos; IR_Valid<=1; PC<=next_pc.
REQ-016 next_pc priority SHALL be: Branch_Taken=1 -> Branch_Target; else (macro branch, REQ-027) -> branch target; else PC+1.
REQ-017 The PC increment SHALL be modulo 2^DATAWIDTH_BUS, so 32'hFFFF_FFFF+1 wraps to 0.
REQ-018 The PC SHALL address words, not bytes.
REQ-019 Fetch_Stall=1 in FETCH SHALL move the FSM to STALL and clear IR_Valid, with PC and IR held.
REQ-020 In STALL, Branch_Taken SHALL be ignored, and a requester must hold it until the stall releases.
REQ-021 Fetch_Stall=0 in STALL SHALL return the FSM to FETCH with no fetch on that edge; the first new IR appears on the following edge.
REQ-022 If the word latched per REQ-015 equals all zeros, the block SHALL enter HALTED on that edge with IR=0, IR_Valid=0 and Halt=1.
REQ-023 In REQ-022, the PC SHALL still advance per REQ-016.
REQ-024 HALTED SHALL freeze PC, IR and Halt, ignore Fetch_Stall and Branch_Taken, and be exited only by reset.
REQ-025 When the halt word and Branch_Taken arrive on the same edge, the halt SHALL win for state and Halt, and the PC SHALL still take Branch_Target.

Reset
REQ-026 RESET_InHigh=1 SHALL set, immediately and independent of the clock: PC=RESET_VECTOR, IR=0, IR_Valid=0, Halt=0, FSM=FETCH; this applies mid-stall and in HALTED. Fetch resumes on the first rising edge after deassertion.

Configuration
REQ-027 With macro IFETCH_LOCAL_BRANCH_EN defined, a fetched word with bits[31:30]=2'b00 and a nonzero value SHALL be a local branch, taking next_pc=PC+signext(bits[21:0]), at lower priority than Branch_Taken.
REQ-028 Without IFETCH_LOCAL_BRANCH_EN, such words SHALL be ordinary instructions with next_pc=PC+1.
REQ-029 With or without the macro, such a word SHALL still be latched into IR with IR_Valid=1.

Verification
REQ-030 Reset test: assert reset, release, clock 3 edges -> BusDirecciones 0x800,0x801,0x802,0x803 and IR=word[0x800],[0x801],[0x802] with IR_Valid=1.
REQ-031 Stall test: stall for 2 cycles at PC=0x804 -> PC holds 0x804, IR_Valid=0 for 2 cycles plus 1 release cycle, then IR=word[0x804].
REQ-032 Redirect test: Branch_Taken=1 with Branch_Target=0x900 at PC=0x802 -> the next BusDirecciones is 0x900 and IR=word[0x802].
REQ-033 Halt test: memory word 0 at 0x80E -> after that edge Halt=1 and IR_Valid=0, and PC stays frozen for 10 cycles under any Branch_Taken or stall.
REQ-034 Macro test: with IFETCH_LOCAL_BRANCH_EN defined, word 0x0CBF_FFFC at 0x807 -> next PC=0x803. Without the macro, next PC=0x808.
REQ-035 Async-reset test: pulse reset between edges while HALTED -> Halt=0 and PC=0x800 before the next edge.
